// File: rtl/axis_router_demux_if.sv
// Bundle of N parallel AXI-Stream channels sharing one parameterised width.
// N=1 gives a plain stream; N=NUM_PORTS gives the packed egress fan-out.
interface axis_router_demux_if #(
  parameter int DW = 32,
  parameter int N  = 1
);
  logic [N*DW-1:0] tdata;
  logic [N-1:0]    tlast;
  logic [N-1:0]    tvalid;
  logic [N-1:0]    tready;

  modport master (output tdata, tlast, tvalid, input tready);
  modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_router_demux.sv
// Egress demux: steers each packet to the port named in its header beat,
// discarding and counting packets whose destination is out of range.
module axis_router_demux #(
  parameter int TDATA_WIDTH = 32,
  parameter int NUM_PORTS   = 4,
  parameter int DEST_WIDTH  = 4,
  parameter int DEST_LSB    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axis_router_demux_if.slave   s_axis,
  axis_router_demux_if.master  m_axis,
  output logic [15:0]          drop_count
);
  localparam int SW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t                 state_q, state_d;
  logic [TDATA_WIDTH-1:0] out_data;
  logic                   out_last, out_valid;
  logic [SW-1:0]          sel;
  logic [DEST_WIDTH-1:0]  dest;
  logic                   dest_ok, out_free, ready, accept, load, drop_hdr;

  assign dest     = s_axis.tdata[DEST_LSB +: DEST_WIDTH];
  assign dest_ok  = {{(32-DEST_WIDTH){1'b0}}, dest} < 32'(NUM_PORTS);
  assign out_free = !out_valid || m_axis.tready[sel];
  assign accept   = s_axis.tvalid[0] && ready;
  assign s_axis.tready[0] = ready;

  always_comb begin
    state_d  = state_q;
    ready    = out_free;
    load     = 1'b0;
    drop_hdr = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (dest_ok) begin
          load = 1'b1;
          if (!s_axis.tlast[0]) state_d = FWD;
        end else begin
          drop_hdr = 1'b1;
          if (!s_axis.tlast[0]) state_d = DROP;
        end
      end
      FWD: if (accept) begin
        load = 1'b1;
        if (s_axis.tlast[0]) state_d = IDLE;
      end
      DROP: begin
        // Discarded beats never touch the output register, so no stall.
        ready = 1'b1;
        if (s_axis.tvalid[0] && s_axis.tlast[0]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
      sel        <= '0;
      drop_count <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        out_data  <= s_axis.tdata;
        out_last  <= s_axis.tlast[0];
        out_valid <= 1'b1;
        if (state_q == IDLE) sel <= SW'(dest);
      end else if (m_axis.tready[sel]) begin
        out_valid <= 1'b0;
      end
      if (drop_hdr && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign m_axis.tvalid[p] = out_valid && (sel == SW'(p));
    assign m_axis.tlast[p]  = out_last;
    assign m_axis.tdata[p*TDATA_WIDTH +: TDATA_WIDTH] = out_data;
  end
endmodule
